// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with handshakes,
// retired-instruction counter and sticky trap on illegal op or memory timeout.
module riscv_mc_ctrl #(
    parameter  int CNT_WIDTH   = 32,
    parameter  int MEM_TIMEOUT = 255,
    localparam int TO_WIDTH    = $clog2(MEM_TIMEOUT + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    output logic                 imem_req_o,
    input  logic                 imem_ack_i,
    output logic                 ir_we_o,
    input  logic                 dec_valid_i,
    input  logic                 dec_load_i,
    input  logic                 dec_store_i,
    input  logic                 dec_rf_wen_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    input  logic                 dmem_ack_i,
    output logic                 rf_we_o,
    output logic                 pc_we_o,
    output logic                 trap_o,
    output logic [1:0]           trap_cause_o,
    output logic [CNT_WIDTH-1:0] retired_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST =
        TO_WIDTH'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
    localparam bit TO_EN = (MEM_TIMEOUT != 0);

    state_t                r_state;
    state_t                w_next;
    logic [TO_WIDTH-1:0]   r_to_cnt;
    logic [CNT_WIDTH-1:0]  r_retired;
    logic                  r_trap;
    logic [1:0]            r_cause;

    logic                  w_to_hit;
    logic                  w_to_inc;
    logic [1:0]            w_cause;
    logic                  w_imem_req;
    logic                  w_ir_we;
    logic                  w_dmem_req;
    logic                  w_dmem_we;
    logic                  w_rf_we;
    logic                  w_pc_we;

    assign w_to_hit = TO_EN && (r_to_cnt == TO_LAST);

    always_comb begin
        w_next     = r_state;
        w_cause    = 2'd0;
        w_to_inc   = 1'b0;
        w_imem_req = 1'b0;
        w_ir_we    = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_rf_we    = 1'b0;
        w_pc_we    = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_imem_req = !stall_i;
                if (w_imem_req && imem_ack_i) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_imem_req) begin
                    if (w_to_hit) begin
                        w_next  = S_TRAP;
                        w_cause = 2'd2;
                    end else begin
                        w_to_inc = TO_EN;
                    end
                end
            end
            S_DECODE: begin
                if (dec_valid_i) begin
                    w_next = S_EXEC;
                end else begin
                    w_next  = S_TRAP;
                    w_cause = 2'd1;
                end
            end
            S_EXEC: begin
                w_next = (dec_load_i | dec_store_i) ? S_MEM : S_WB;
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = dec_store_i;
                if (dmem_ack_i) begin
                    w_next = S_WB;
                end else if (w_to_hit) begin
                    w_next  = S_TRAP;
                    w_cause = 2'd3;
                end else begin
                    w_to_inc = TO_EN;
                end
            end
            S_WB: begin
                w_rf_we = dec_rf_wen_i & !dec_store_i;
                w_pc_we = 1'b1;
                w_next  = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_to_cnt  <= '0;
            r_retired <= '0;
            r_trap    <= 1'b0;
            r_cause   <= 2'd0;
        end else begin
            r_state <= w_next;
            // Counter is zero on every entry to a waiting state
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_state == S_WB) begin
                r_retired <= r_retired + 1'b1;
            end
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    assign imem_req_o   = w_imem_req & ~rst;
    assign ir_we_o      = w_ir_we & ~rst;
    assign dmem_req_o   = w_dmem_req & ~rst;
    assign dmem_we_o    = w_dmem_we & ~rst;
    assign rf_we_o      = w_rf_we & ~rst;
    assign pc_we_o      = w_pc_we & ~rst;
    assign trap_o       = r_trap;
    assign trap_cause_o = r_cause;
    assign retired_o    = r_retired;
    assign state_o      = r_state;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Vector-table bench for riscv_mc_ctrl (CNT_WIDTH=4, MEM_TIMEOUT=4)
// plus hand-written wrap and trap-absorption sequences.
module tb_riscv_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall_i = 1'b0;
    logic       imem_ack_i = 1'b0;
    logic       dec_valid_i = 1'b0;
    logic       dec_load_i = 1'b0;
    logic       dec_store_i = 1'b0;
    logic       dec_rf_wen_i = 1'b0;
    logic       dmem_ack_i = 1'b0;
    logic       imem_req_o;
    logic       ir_we_o;
    logic       dmem_req_o;
    logic       dmem_we_o;
    logic       rf_we_o;
    logic       pc_we_o;
    logic       trap_o;
    logic [1:0] trap_cause_o;
    logic [3:0] retired_o;
    logic [2:0] state_o;

    riscv_mc_ctrl #(.CNT_WIDTH(4), .MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .imem_req_o   (imem_req_o),
        .imem_ack_i   (imem_ack_i),
        .ir_we_o      (ir_we_o),
        .dec_valid_i  (dec_valid_i),
        .dec_load_i   (dec_load_i),
        .dec_store_i  (dec_store_i),
        .dec_rf_wen_i (dec_rf_wen_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_ack_i   (dmem_ack_i),
        .rf_we_o      (rf_we_o),
        .pc_we_o      (pc_we_o),
        .trap_o       (trap_o),
        .trap_cause_o (trap_cause_o),
        .retired_o    (retired_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // in : {rst, stall, iack, valid, load, store, rf_wen, dack}
    // exp: {ireq, ir_we, dreq, dwe, rf_we, pc_we, trap, cause[1:0], state[2:0]}
    typedef struct {
        logic [7:0]  in;
        logic [11:0] exp;
        logic [3:0]  ret;
    } vec_t;

    vec_t tv[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic [7:0] in, input logic [11:0] exp,
                       input logic [3:0] ret);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        v.ret = ret;
        tv.push_back(v);
    endtask

    task automatic drive(input logic [7:0] in);
        {rst, stall_i, imem_ack_i, dec_valid_i,
         dec_load_i, dec_store_i, dec_rf_wen_i, dmem_ack_i} = in;
    endtask

    function automatic logic [11:0] outs();
        return {imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o,
                pc_we_o, trap_o, trap_cause_o, state_o};
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int pcw;
        int cyc;
        // reset
        add(8'b1_0_0_0_0_0_0_0, 12'b1_0_0_0_0_0_0_00_000 & 12'h0ff, 4'd0);
        // ADDI
        add(8'b0_0_1_1_0_0_1_0, 12'b0_1_1_0_0_0_0_0_00_000, 4'd0);
        add(8'b0_0_0_1_0_0_1_0, 12'b0_0_0_0_0_0_0_0_00_001, 4'd0);
        add(8'b0_0_0_1_0_0_1_0, 12'b0_0_0_0_0_0_0_0_00_010, 4'd0);
        add(8'b0_0_0_1_0_0_1_0, 12'b0_0_0_0_0_1_1_0_00_100, 4'd0);
        // LW, ack on fourth MEM cycle
        add(8'b0_0_1_1_1_0_1_0, 12'b0_1_1_0_0_0_0_0_00_000, 4'd1);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_0_0_0_0_0_00_001, 4'd1);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_0_0_0_0_0_00_010, 4'd1);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_1_0_0_0_0_00_011, 4'd1);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_1_0_0_0_0_00_011, 4'd1);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_1_0_0_0_0_00_011, 4'd1);
        add(8'b0_0_0_1_1_0_1_1, 12'b0_0_0_1_0_0_0_0_00_011, 4'd1);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_0_0_1_1_0_00_100, 4'd1);
        // SW with rf_wen set: write strobe must stay low
        add(8'b0_0_1_1_0_1_1_0, 12'b0_1_1_0_0_0_0_0_00_000, 4'd2);
        add(8'b0_0_0_1_0_1_1_0, 12'b0_0_0_0_0_0_0_0_00_001, 4'd2);
        add(8'b0_0_0_1_0_1_1_0, 12'b0_0_0_0_0_0_0_0_00_010, 4'd2);
        add(8'b0_0_0_1_0_1_1_1, 12'b0_0_0_1_1_0_0_0_00_011, 4'd2);
        add(8'b0_0_0_1_0_1_1_0, 12'b0_0_0_0_0_0_1_0_00_100, 4'd2);
        // stalled fetch ignores ack; then load+store -> store wins
        add(8'b0_1_1_1_1_1_0_0, 12'b0_0_0_0_0_0_0_0_00_000, 4'd3);
        add(8'b0_1_1_1_1_1_0_0, 12'b0_0_0_0_0_0_0_0_00_000, 4'd3);
        add(8'b0_0_1_1_1_1_0_0, 12'b0_1_1_0_0_0_0_0_00_000, 4'd3);
        add(8'b0_0_0_1_1_1_0_0, 12'b0_0_0_0_0_0_0_0_00_001, 4'd3);
        add(8'b0_0_0_1_1_1_0_0, 12'b0_0_0_0_0_0_0_0_00_010, 4'd3);
        add(8'b0_0_0_1_1_1_0_1, 12'b0_0_0_1_1_0_0_0_00_011, 4'd3);
        add(8'b0_0_0_1_1_1_0_0, 12'b0_0_0_0_0_0_1_0_00_100, 4'd3);
        // fetch timeout: 3 req, 2 stalled (held), 1 req -> trap cause 2
        add(8'b0_0_0_1_0_0_0_0, 12'b0_1_0_0_0_0_0_0_00_000, 4'd4);
        add(8'b0_0_0_1_0_0_0_0, 12'b0_1_0_0_0_0_0_0_00_000, 4'd4);
        add(8'b0_0_0_1_0_0_0_0, 12'b0_1_0_0_0_0_0_0_00_000, 4'd4);
        add(8'b0_1_0_1_0_0_0_0, 12'b0_0_0_0_0_0_0_0_00_000, 4'd4);
        add(8'b0_1_0_1_0_0_0_0, 12'b0_0_0_0_0_0_0_0_00_000, 4'd4);
        add(8'b0_0_0_1_0_0_0_0, 12'b0_1_0_0_0_0_0_0_00_000, 4'd4);
        add(8'b0_0_1_1_0_0_0_0, 12'b0_0_0_0_0_0_0_1_10_101, 4'd4);
        add(8'b0_1_0_1_0_0_0_0, 12'b0_0_0_0_0_0_0_1_10_101, 4'd4);
        // reset clears trap; illegal instruction -> cause 1
        add(8'b1_0_0_0_0_0_0_0, 12'b0_0_0_0_0_0_0_0_00_000, 4'd0);
        add(8'b0_0_1_0_0_0_1_0, 12'b0_1_1_0_0_0_0_0_00_000, 4'd0);
        add(8'b0_0_0_0_0_0_1_0, 12'b0_0_0_0_0_0_0_0_00_001, 4'd0);
        add(8'b0_0_1_0_0_0_1_1, 12'b0_0_0_0_0_0_0_1_01_101, 4'd0);
        add(8'b0_1_1_0_0_0_1_1, 12'b0_0_0_0_0_0_0_1_01_101, 4'd0);
        // reset mid-MEM drops dmem_req immediately
        add(8'b1_0_0_0_0_0_0_0, 12'b0_0_0_0_0_0_0_0_00_000, 4'd0);
        add(8'b0_0_1_1_1_0_1_0, 12'b0_1_1_0_0_0_0_0_00_000, 4'd0);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_0_0_0_0_0_00_001, 4'd0);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_0_0_0_0_0_00_010, 4'd0);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_1_0_0_0_0_00_011, 4'd0);
        add(8'b1_0_0_1_1_0_1_0, 12'b0_0_0_0_0_0_0_0_00_000, 4'd0);
        // data timeout -> trap cause 3
        add(8'b0_0_1_1_1_0_1_0, 12'b0_1_1_0_0_0_0_0_00_000, 4'd0);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_0_0_0_0_0_00_001, 4'd0);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_0_0_0_0_0_00_010, 4'd0);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_1_0_0_0_0_00_011, 4'd0);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_1_0_0_0_0_00_011, 4'd0);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_1_0_0_0_0_00_011, 4'd0);
        add(8'b0_0_0_1_1_0_1_0, 12'b0_0_0_1_0_0_0_0_00_011, 4'd0);
        add(8'b0_0_0_1_1_0_1_1, 12'b0_0_0_0_0_0_0_1_11_101, 4'd0);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i].in);
            #1;
            check($sformatf("vec%0d", i),
                  {outs(), retired_o}, {tv[i].exp, tv[i].ret});
        end

        // trap is absorbing under arbitrary non-reset inputs
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive({1'b0, 7'($urandom_range(0, 127))});
            #1;
            check($sformatf("trap_hold%0d", i), {outs(), retired_o},
                  {12'b0_0_0_0_0_0_0_1_11_101, 4'd0});
        end

        // 17 ALU instructions with a 4-bit counter wrap to 1
        @(negedge clk);
        drive(8'b1_0_0_0_0_0_0_0);
        pcw = 0;
        cyc = 0;
        for (int i = 0; i < 17; i++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                drive(c == 0 ? 8'b0_0_1_1_0_0_1_0 : 8'b0_0_0_1_0_0_1_0);
                #1;
                cyc++;
                if (pc_we_o) pcw++;
            end
        end
        @(negedge clk);
        drive(8'b0_1_0_1_0_0_0_0);
        #1;
        check("wrap_retired", 16'(retired_o), 16'd1);
        check("wrap_state", 16'(state_o), 16'd0);
        check("wrap_pc_we_count", 16'(pcw), 16'd17);
        check("wrap_cycles", 16'(cyc), 16'd68);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
Multi-cycle sequencer for the single-issue RV32I core. It runs each instruction through FETCH, DECODE, EXEC, optional MEM, and WB. It drives the instruction and data memory request/ack handshakes, the IR/PC/register-file write enables, a retired-instruction counter, and a sticky trap on illegal instructions or memory timeouts. Decode-class inputs come from the instruction decoder; mux selects (op1/op2/wb/pc) pass from the decoder to the datapath directly and are not handled here.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter
MEM_TIMEOUT, 255, max cycles a memory request may wait for ack; 0 disables the timeout
TO_WIDTH, $clog2(MEM_TIMEOUT+2), timeout counter width (derived, not overridden)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
stall_i  in  1  hold before issuing a fetch
imem_req_o  out  1  instruction fetch request
imem_ack_i  in  1  fetch complete; instruction valid this cycle
ir_we_o  out  1  load instruction register
dec_valid_i  in  1  decoder recognises instruction (1 = legal)
dec_load_i  in  1  instruction is LW
dec_store_i  in  1  instruction is SW
dec_rf_wen_i  in  1  decoder requests register write
dmem_req_o  out  1  data memory request
dmem_we_o  out  1  data request is a write
dmem_ack_i  in  1  data access complete; load data valid this cycle
rf_we_o  out  1  register-file write strobe
pc_we_o  out  1  PC update strobe
trap_o  out  1  sticky trap flag
trap_cause_o  out  2  0 none, 1 illegal, 2 imem timeout, 3 dmem timeout
retired_o  out  CNT_WIDTH  retired-instruction count
state_o  out  3  current state (debug): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5

Behaviour:
- Reset (async, any state): state=FETCH; retired_o=0; trap_o=0; trap_cause_o=0; timeout counter=0. All strobes and requests read 0 while rst is high. An in-flight request is abandoned; a late ack after reset is treated as a normal ack only if a new request is active.
- Strobe and request outputs are decoded combinationally from the state and the current inputs. Counters, trap and state are registered.
- FETCH:
  - imem_req_o = !stall_i.
  - If the request is active and imem_ack_i=1: ir_we_o=1 in the same cycle, next state DECODE.
  - While stalled, the timeout counter is held.
  - Each non-acked requesting cycle increments the counter. If the counter reaches MEM_TIMEOUT without an ack: TRAP, cause 2.
- DECODE (1 cycle): dec_valid_i=0 -> TRAP, cause 1. Otherwise -> EXEC.
- EXEC (1 cycle): (dec_load_i | dec_store_i) -> MEM; otherwise -> WB.
- MEM:
  - dmem_req_o=1; dmem_we_o=dec_store_i. Store takes priority if both load and store are set.
  - dmem_ack_i=1 -> WB.
  - Timeout works as in FETCH -> TRAP, cause 3.
- WB (1 cycle): rf_we_o=dec_rf_wen_i & !dec_store_i; pc_we_o=1; retired_o increments and wraps modulo 2^CNT_WIDTH; next state FETCH.
- TRAP: absorbing until rst. All requests and strobes are 0; trap_o=1; cause frozen; retired_o frozen.
- Timeout counter clears on every entry to FETCH and MEM.
- Acks arriving while the corresponding request is low are ignored.
- Throughput with zero-wait acks: 4 cycles per ALU/branch/jump instruction, 5 cycles per load/store.
- Decoder inputs must be stable from DECODE through WB; the IR holds them.

Test Plan:
- Reset then ADDI (dec_valid=1, rf_wen=1), imem_ack in the first FETCH cycle -> state sequence 0,1,2,4,0; ir_we pulses at cycle 0; rf_we and pc_we pulse at cycle 3; retired_o=1.
- LW with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0; rf_we=1 in WB; total 8 cycles; retired_o increments by 1.
- SW, immediate ack -> dmem_req=1 and dmem_we=1 for 1 cycle; rf_we=0; pc_we=1; 5 cycles.
- dec_valid=0 in DECODE -> trap_o=1 and cause=1 from the next cycle. Later acks and stall toggling produce no requests or strobes; retired_o unchanged.
- MEM_TIMEOUT=4: no imem_ack -> imem_req high exactly 4 cycles, then TRAP with cause=2. Repeat with stall_i=1 for 10 cycles first: no trap and no req during the stall.
- CNT_WIDTH=4: retire 17 ALU instructions -> retired_o = 1. Assert rst mid-MEM -> dmem_req drops in the same cycle; state=0, outputs 0.
